// File: rtl/mc_controller_wait_pkg.sv
// Shared types and encodings for the multi-cycle ARM-subset controller.
// State enum, ALU opcodes, instruction field constants and mux select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_MULEX   = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_UNKNOWN = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  // Unrecognised data-processing commands fall back to ADD.
  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_decode = ALU_ADD;
      CMD_SUB: alu_decode = ALU_SUB;
      CMD_CMP: alu_decode = ALU_SUB;
      CMD_AND: alu_decode = ALU_AND;
      CMD_ORR: alu_decode = ALU_ORR;
      CMD_EOR: alu_decode = ALU_EOR;
      CMD_MOV: alu_decode = ALU_MOV;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_wait_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface mc_controller_wait_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite;
  logic        MemWrite;
  logic        MemRead;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic        MulDst;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags;

  modport master (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, MemWrite, MemRead, RegWrite, IRWrite, AdrSrc, RegSrc,
           MulDst, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Flags
  );

  modport slave (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, MemWrite, MemRead, RegWrite, IRWrite, AdrSrc, RegSrc,
           MulDst, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Flags
  );
endinterface

// File: rtl/mc_condcheck.sv
// ARM condition-code evaluation against the registered NZCV flags.
module mc_condcheck
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_condex
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_flags;

  always_comb begin
    o_condex = 1'b0;
    case (i_cond)
      COND_EQ: o_condex = w_z;
      COND_NE: o_condex = ~w_z;
      COND_CS: o_condex = w_c;
      COND_CC: o_condex = ~w_c;
      COND_MI: o_condex = w_n;
      COND_PL: o_condex = ~w_n;
      COND_VS: o_condex = w_v;
      COND_VC: o_condex = ~w_v;
      COND_HI: o_condex = w_c & ~w_z;
      COND_LS: o_condex = ~w_c | w_z;
      COND_GE: o_condex = ~(w_n ^ w_v);
      COND_LT: o_condex = w_n ^ w_v;
      COND_GT: o_condex = ~w_z & ~(w_n ^ w_v);
      COND_LE: o_condex = w_z | (w_n ^ w_v);
      COND_AL: o_condex = 1'b1;
      default: o_condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller_wait.sv
// Multi-cycle ARM-subset controller: Moore main FSM, NZCV flag register,
// memory wait-state handshake and multi-cycle multiply sequencing.
module mc_controller_wait
  import mc_ctrl_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          MUL_EN      = 1'b1,
  parameter int unsigned MUL_LAT     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_controller_wait_if.master bus
);

  state_t     r_state, w_next;
  logic [3:0] r_flags;
  logic [3:0] r_mulcnt;

  logic [1:0] w_op;
  logic [3:0] w_cmd, w_cond, w_dst;
  logic       w_i, w_s, w_l;
  logic       w_ready, w_is_mul, w_is_cmp, w_condex, w_dst_pc;
  logic [2:0] w_dp_alu;
  logic [1:0] w_flagw;
  logic       w_unused;

  assign w_op     = bus.Instr[27:26];
  assign w_i      = bus.Instr[25];
  assign w_cmd    = bus.Instr[24:21];
  assign w_s      = bus.Instr[20];
  assign w_l      = bus.Instr[20];
  assign w_cond   = bus.Instr[31:28];
  assign w_unused = ^{bus.Instr[11:8], bus.Instr[3:0]};

  assign w_ready  = MEM_WAIT_EN ? bus.MemReady : 1'b1;
  assign w_is_mul = MUL_EN && (w_op == OP_DP) && !w_i && (w_cmd == CMD_AND)
                    && (bus.Instr[7:4] == 4'b1001);
  assign w_is_cmp = (w_cmd == CMD_CMP);
  assign w_dp_alu = alu_decode(w_cmd);
  // MUL writes Instr[19:16]; the PC-destination check follows the real destination.
  assign w_dst    = w_is_mul ? bus.Instr[19:16] : bus.Instr[15:12];
  assign w_dst_pc = (w_dst == 4'hF);

  mc_condcheck u_condcheck (
    .i_cond   (w_cond),
    .i_flags  (r_flags),
    .o_condex (w_condex)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_DP:   w_next = w_is_mul ? S_MULEX : (w_i ? S_EXECI : S_EXECR);
          OP_MEM:  w_next = S_MEMADR;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_UNKNOWN;
        endcase
      end
      S_MEMADR: w_next = w_l ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (w_ready) w_next = S_FETCH;
      S_EXECR,
      S_EXECI:  w_next = w_is_cmp ? S_FETCH : S_ALUWB;
      S_MULEX:  if (r_mulcnt == 4'd0) w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_flagw = 2'b00;
    if (r_state == S_EXECR || r_state == S_EXECI) begin
      if (w_is_cmp)
        w_flagw = 2'b11;
      else if (w_s)
        w_flagw = (w_dp_alu == ALU_ADD || w_dp_alu == ALU_SUB) ? 2'b11 : 2'b10;
    end else if (r_state == S_MULEX && r_mulcnt == 4'd0 && w_s) begin
      w_flagw = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_flags  <= '0;
      r_mulcnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_flagw[1] && w_condex) r_flags[3:2] <= bus.ALUFlags[3:2];
      if (w_flagw[0] && w_condex) r_flags[1:0] <= bus.ALUFlags[1:0];
      if (r_state == S_DECODE && w_next == S_MULEX)
        r_mulcnt <= 4'(MUL_LAT - 1);
      else if (r_state == S_MULEX && r_mulcnt != 4'd0)
        r_mulcnt <= r_mulcnt - 4'd1;
    end
  end

  logic       w_pcwrite, w_memwrite, w_regwrite, w_irwrite;
  logic       w_memread, w_adrsrc, w_muldst;
  logic [1:0] w_srca, w_srcb, w_ressrc;
  logic [2:0] w_aluctl;

  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_memread  = 1'b0;
    w_adrsrc   = 1'b0;
    w_muldst   = 1'b0;
    w_srca     = SRCA_RD1;
    w_srcb     = SRCB_RD2;
    w_ressrc   = RES_ALUOUT;
    w_aluctl   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_srca    = SRCA_PC;
        w_srcb    = SRCB_FOUR;
        w_ressrc  = RES_ALURES;
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
      end
      S_DECODE: begin
        w_srca = SRCA_PC;
        w_srcb = SRCB_FOUR;
      end
      S_MEMADR: w_srcb = SRCB_IMM;
      S_MEMRD: begin
        w_memread = 1'b1;
        w_adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        w_ressrc   = RES_DATA;
        w_regwrite = w_condex;
      end
      S_MEMWR: begin
        w_adrsrc   = 1'b1;
        w_memwrite = w_condex;
      end
      S_EXECR: w_aluctl = w_dp_alu;
      S_EXECI: begin
        w_srcb   = SRCB_IMM;
        w_aluctl = w_dp_alu;
      end
      S_MULEX: w_aluctl = ALU_MUL;
      S_ALUWB: begin
        w_muldst   = w_is_mul;
        w_pcwrite  = w_condex & w_dst_pc;
        w_regwrite = w_condex & ~w_dst_pc;
      end
      S_BRANCH: begin
        w_srca    = SRCA_ALUOUT;
        w_srcb    = SRCB_IMM;
        w_ressrc  = RES_ALURES;
        w_pcwrite = w_condex;
      end
      default: ;
    endcase
  end

  // Write enables are forced low combinationally while reset is held.
  assign bus.PCWrite    = w_pcwrite  & ~reset;
  assign bus.MemWrite   = w_memwrite & ~reset;
  assign bus.RegWrite   = w_regwrite & ~reset;
  assign bus.IRWrite    = w_irwrite  & ~reset;
  assign bus.MemRead    = w_memread;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.MulDst     = w_muldst;
  assign bus.RegSrc     = {w_op == OP_MEM, w_op == OP_BR};
  assign bus.ALUSrcA    = w_srca;
  assign bus.ALUSrcB    = w_srcb;
  assign bus.ResultSrc  = w_ressrc;
  assign bus.ImmSrc     = w_op;
  assign bus.ALUControl = w_aluctl;
  assign bus.Flags      = r_flags;

endmodule
